flex_counter_rollover: RTL
==========================

# flex_counter_rollover

Two-level parametrised counter for the AES datapath control. An inner counter runs over a runtime-programmable range, with a rollover flag. An outer wrap counter tallies completed inner passes and raises `done_flag` after `NUM_WRAPS` passes, for example 16 bytes per round × 10 rounds. It replaces fixed-threshold counting in the round/byte sequencing logic with a single block that has a synchronous clear.

## Interface
- `NUM_CNT_BITS`, default 4: width of inner counter, `count_out` and `rollover_val`.
- `NUM_WRAP_BITS`, default 4: width of `wrap_count`.
- `NUM_WRAPS`, default 10: completed inner passes before done. Legal range is 1..2^NUM_WRAP_BITS−1.
- `clk`, input, 1: single clock, rising-edge.
- `n_rst`, input, 1: asynchronous, active-low reset.
- `clear`, input, 1: synchronous clear of all state.
- `count_enable`, input, 1: advance inner counter this cycle.
- `rollover_val`, input, NUM_CNT_BITS: inner terminal value, sampled every cycle.
- `count_out`, output, NUM_CNT_BITS: inner count, registered.
- `rollover_flag`, output, 1: registered; high while `count_out == rollover_val`.
- `wrap_count`, output, NUM_WRAP_BITS: completed inner passes, registered.
- `done_flag`, output, 1: registered; high once `wrap_count` reaches `NUM_WRAPS`.

## Operation
- **Reset** (`n_rst` low, asynchronous): `count_out`=0, `rollover_flag`=0, `wrap_count`=0, `done_flag`=0.
- **Priority**, highest first: reset, `clear`, done-hold, `count_enable`, idle hold.
- **Clear**: at the next edge all four outputs become 0, regardless of `count_enable`.
- **Increment**: with `count_enable`=1, not done, and `count_out != rollover_val`: `count_out` ← `count_out`+1, modulo 2^NUM_CNT_BITS.
- **Wrap**: with `count_enable`=1, not done, and `count_out == rollover_val`:
  - `count_out` ← 1, or 0 if `rollover_val`=0.
  - `wrap_count` ← `wrap_count`+1.
- **Done**: when a wrap makes `wrap_count == NUM_WRAPS`, `done_flag` ← 1 on the same edge.
- **Done-hold** (default build): while `done_flag`=1, `count_enable` is ignored and all outputs hold until `clear` or reset.
- **rollover_flag**: computed from the next count and the current `rollover_val`, then registered. It is therefore exact on the cycle `count_out` is presented.
- **Idle**: with `count_enable`=0, all outputs hold. `rollover_flag` still tracks changes to `rollover_val`.
- **rollover_val = 0**: count holds at 0, `rollover_flag`=1, and every enabled cycle is a wrap.
- **rollover_val lowered below `count_out` mid-pass**: counting continues to 2^NUM_CNT_BITS−1, then natural overflow to 0. No wrap is counted. Counting then proceeds to the new value.
- **Wrap counter overflow**: `wrap_count` never exceeds `NUM_WRAPS`.

## Timing
- All outputs are registered. Every response appears one clock after the controlling input is sampled, except the asynchronous reset.
- `clear` and `count_enable` are sampled at the rising edge.
- `clear` asserted in the same cycle as a wrap: clear wins, and no wrap is recorded.
- Reset asserted mid-pass: outputs go to zero immediately. Counting resumes from 0 on the first enabled edge after `n_rst` rises.
- No combinational path from any input to any output.

## Configuration
- Macro: `FLEX_COUNTER_AUTO_RESTART_EN`.
- **Undefined (default)**: done-hold as above; `done_flag` is sticky until `clear` or reset.
- **Defined**:
  - The completing wrap sets `done_flag`=1 for exactly one cycle.
  - `wrap_count` is forced to 0 on that same edge instead of reaching `NUM_WRAPS`.
  - `count_out` takes its normal wrap value.
  - Counting continues uninterrupted, and no enable cycle is lost.
  - `clear` and reset behave identically in both builds.

## Test plan
- **Full run** (defaults, `rollover_val`=3, `NUM_WRAPS`=2, enable held from reset release): `count_out` follows 1,2,3,1,2,3,1 on edges 1–7. `rollover_flag` is high after edges 3 and 6. `wrap_count` is 1 after edge 4 and 2 after edge 7. `done_flag`=1 after edge 7. Outputs hold over 5 further enabled cycles.
- **Enable gaps**: with `rollover_val`=5, toggle enable 1,0,1,0 for 10 cycles. `count_out` advances only on enabled edges and reaches 5 with the flag high after the 5th enabled edge.
- **Clear collision**: `clear`=1 coinciding with the wrap edge at `count_out`=3 → next state is all zero and `wrap_count` stays 0.
- **Edge rollover values**:
  - `rollover_val`=0 with enable held → `count_out`=0, flag=1, `wrap_count` increments every edge.
  - `rollover_val`=15 (NUM_CNT_BITS=4) → count reaches 15, then wraps to 1.
- **Mid-pass change**: at `count_out`=6, change `rollover_val` from 8 to 2 → count goes 7…15, 0, 1, 2 with the flag at 2 and no wrap counted; the next enabled edge wraps to 1.
- **Auto-restart build**: same stimulus as the full run with `FLEX_COUNTER_AUTO_RESTART_EN` defined → `done_flag` is a single-cycle pulse after edge 7, `wrap_count`=0 after edge 7, and `count_out`=2 after edge 8.

Source files
------------

// File: rtl/flex_counter_rollover.sv
// Two-level counter: an inner counter over a runtime range plus an outer wrap counter with done flag.
// Optional build macro FLEX_COUNTER_AUTO_RESTART_EN turns the sticky done into a one-cycle pulse.
module flex_counter_rollover #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int NUM_WRAP_BITS = 4,
    parameter int NUM_WRAPS     = 10
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     count_enable,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic [NUM_WRAP_BITS-1:0] wrap_count,
    output logic                     done_flag
);

`ifdef FLEX_COUNTER_AUTO_RESTART_EN
    localparam bit AUTO_RESTART = 1'b1;
`else
    localparam bit AUTO_RESTART = 1'b0;
`endif

    localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE   = NUM_CNT_BITS'(1);
    localparam logic [NUM_WRAP_BITS-1:0] WRAP_ONE  = NUM_WRAP_BITS'(1);
    localparam logic [NUM_WRAP_BITS-1:0] WRAP_LAST = NUM_WRAP_BITS'(NUM_WRAPS - 1);
    localparam logic [NUM_WRAP_BITS-1:0] WRAP_MAX  = NUM_WRAP_BITS'(NUM_WRAPS);

    logic [NUM_CNT_BITS-1:0]  count_q, count_d;
    logic                     rollover_flag_q, rollover_flag_d;
    logic [NUM_WRAP_BITS-1:0] wrap_count_q, wrap_count_d;
    logic                     done_flag_q, done_flag_d;

    logic at_terminal;
    logic done_hold;

    assign at_terminal = (count_q == rollover_val);
    assign done_hold   = done_flag_q && !AUTO_RESTART;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        count_d      = count_q;
        wrap_count_d = wrap_count_q;
        done_flag_d  = AUTO_RESTART ? 1'b0 : done_flag_q;

        if (clear) begin
            count_d      = '0;
            wrap_count_d = '0;
            done_flag_d  = 1'b0;
        end else if (done_hold) begin
            count_d      = count_q;
        end else if (count_enable) begin
            if (at_terminal) begin
                count_d = (rollover_val == '0) ? '0 : CNT_ONE;
                if (wrap_count_q == WRAP_LAST) begin
                    done_flag_d  = 1'b1;
                    wrap_count_d = AUTO_RESTART ? '0 : WRAP_MAX;
                end else if (wrap_count_q < WRAP_MAX) begin
                    wrap_count_d = wrap_count_q + WRAP_ONE;
                end
            end else begin
                // Past a lowered terminal value this overflows naturally to 0 without a wrap.
                count_d = count_q + CNT_ONE;
            end
        end

        // Flag looks ahead at the next count so it is exact when count_out updates.
        rollover_flag_d = clear ? 1'b0 : (count_d == rollover_val);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!n_rst) begin
            count_q         <= '0;
            rollover_flag_q <= 1'b0;
            wrap_count_q    <= '0;
            done_flag_q     <= 1'b0;
        end else begin
            count_q         <= count_d;
            rollover_flag_q <= rollover_flag_d;
            wrap_count_q    <= wrap_count_d;
            done_flag_q     <= done_flag_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = rollover_flag_q;
    assign wrap_count    = wrap_count_q;
    assign done_flag     = done_flag_q;

endmodule
